// File: rtl/seq_detect_ctrl_if.sv
// Bundle between the run controller, the board inputs and the serial sequence detector.
// The master modport is the controller's view of the bundle.
interface seq_detect_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             button;
    logic [WIDTH-1:0] switch;
    logic             det_clr;
    logic             det_bit;
    logic             det_valid;
    logic             det_hit;
    logic             busy;
    logic [CNT_W-1:0] hit_count;
    logic             done;
    logic             led;

    modport master (
        input  button, switch, det_hit,
        output det_clr, det_bit, det_valid, busy, hit_count, done, led
    );

    modport slave (
        output button, switch, det_hit,
        input  det_clr, det_bit, det_valid, busy, hit_count, done, led
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller: captures the switch word on a button edge, clears the detector,
// streams the word MSB first, counts registered match flags and reports the result.
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    seq_detect_ctrl_if.master bus
);
    localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic             button_d_reg;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [BC_W-1:0]  bitcnt_reg, bitcnt_next;
    logic             valid_d_reg;
    logic [CNT_W-1:0] hit_count_reg, hit_count_next;
    logic             led_reg, led_next;
    logic             det_clr_reg, det_bit_reg, det_valid_reg, done_reg, busy_reg;
    logic             start;
    logic             hit_sample;

    assign start      = bus.button & ~button_d_reg;
    // det_hit is registered by the detector, so it belongs to the bit valid one cycle ago
    assign hit_sample = valid_d_reg & bus.det_hit;

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bitcnt_next    = bitcnt_reg;
        led_next       = led_reg;
        hit_count_next = hit_count_reg;
        if (hit_sample && (hit_count_reg != CNT_MAX)) begin
            hit_count_next = hit_count_reg + 1'b1;
        end
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    shreg_next = bus.switch;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                hit_count_next = '0;
                led_next       = 1'b0;
                bitcnt_next    = '0;
                state_next     = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_next  = shreg_reg << 1;
                bitcnt_next = bitcnt_reg + 1'b1;
                if (bitcnt_reg == LAST_BIT) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                led_next   = (hit_count_reg != '0) | hit_sample;
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            button_d_reg  <= 1'b1;
            shreg_reg     <= '0;
            bitcnt_reg    <= '0;
            valid_d_reg   <= 1'b0;
            hit_count_reg <= '0;
            led_reg       <= 1'b0;
            det_clr_reg   <= 1'b0;
            det_bit_reg   <= 1'b0;
            det_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            button_d_reg  <= bus.button;
            shreg_reg     <= shreg_next;
            bitcnt_reg    <= bitcnt_next;
            valid_d_reg   <= det_valid_reg;
            hit_count_reg <= hit_count_next;
            led_reg       <= led_next;
            det_clr_reg   <= (state_next == S_CLEAR);
            det_valid_reg <= (state_next == S_SHIFT);
            det_bit_reg   <= (state_next == S_SHIFT) ? shreg_next[WIDTH-1] : 1'b0;
            done_reg      <= (state_next == S_DONE);
            busy_reg      <= (state_next != S_IDLE);
        end
    end

    assign bus.det_clr   = det_clr_reg;
    assign bus.det_bit   = det_bit_reg;
    assign bus.det_valid = det_valid_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = busy_reg;
    assign bus.hit_count = hit_count_reg;
    assign bus.led       = led_reg;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a stub "101" detector on one instance, det_hit tied high on a
// CNT_W=2 instance; expected runs go into a queue and a monitor checks each done.
module tb_seq_detect_ctrl;
    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int CW_B = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_ctrl_if #(.WIDTH(W), .CNT_W(CW))   a_if ();
    seq_detect_ctrl_if #(.WIDTH(W), .CNT_W(CW_B)) b_if ();

    seq_detect_ctrl #(.WIDTH(W), .CNT_W(CW))   dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
    seq_detect_ctrl #(.WIDTH(W), .CNT_W(CW_B)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

    // Stub detector: registered, overlapping "101" over the valid bits since the last clear
    logic [1:0] hist;
    logic       stub_hit;
    always @(posedge clk) begin
        if (rst || a_if.det_clr) begin
            hist     <= 2'b00;
            stub_hit <= 1'b0;
        end else if (a_if.det_valid) begin
            hist     <= {hist[0], a_if.det_bit};
            stub_hit <= ({hist, a_if.det_bit} == 3'b101);
        end else begin
            stub_hit <= 1'b0;
        end
    end
    assign a_if.det_hit = stub_hit;
    assign b_if.det_hit = 1'b1;

    typedef struct {
        logic [W-1:0] word;
        int           count;
        logic         led;
        int           done_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: count overlapping 101 windows in the MSB-first word, saturate at 2^cnt_w-1
    function automatic int ref_hits(logic [W-1:0] w, int cnt_w);
        int n = 0;
        int lim = (1 << cnt_w) - 1;
        for (int i = W - 1; i >= 2; i--) begin
            if (w[i] && !w[i-1] && w[i-2]) n++;
        end
        return (n > lim) ? lim : n;
    endfunction

    // Monitor for instance A
    logic [W-1:0] stream;
    int           nvalid = 0;
    int           nclr = 0;
    int           ndone = 0;
    bit           active = 0;
    bit           after_clr = 0;
    exp_t         e;
    always @(negedge clk) begin
        if (rst) begin
            stream    = '0;
            nvalid    = 0;
            nclr      = 0;
            active    = 0;
            after_clr = 0;
        end else begin
            if (after_clr) begin
                check("led cleared at CLEAR", a_if.led, 1'b0);
                check("count cleared at CLEAR", a_if.hit_count, 0);
                after_clr = 0;
            end
            if (a_if.det_clr) begin
                active    = 1;
                after_clr = 1;
                nclr++;
                stream    = '0;
                nvalid    = 0;
            end
            check("busy", a_if.busy, active);
            if (a_if.det_valid) begin
                stream = {stream[W-2:0], a_if.det_bit};
                nvalid++;
            end else if (a_if.det_bit !== 1'b0) begin
                check("det_bit idle", a_if.det_bit, 1'b0);
            end
            if (a_if.done) begin
                ndone++;
                if (sb.size() == 0) begin
                    check("unexpected done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("stream", stream, e.word);
                    check("valid cycles", nvalid, W);
                    check("clr pulses", nclr, 1);
                    check("hit_count", a_if.hit_count, e.count);
                    check("led", a_if.led, e.led);
                    check("done cycle", cyc, e.done_cyc);
                    $display("run word=%b hits=%0d led=%0d done@%0d", e.word, a_if.hit_count, a_if.led, cyc);
                end
                active = 0;
                nclr   = 0;
            end
        end
    end

    // One run on A; extra=1 re-presses and changes switch mid-stream; rst_at>0 aborts
    // the run with a reset in that SHIFT cycle.
    task automatic press_a(logic [W-1:0] w, bit extra, int rst_at);
        int t;
        int n0;
        int h;
        n0 = ndone;
        h  = ref_hits(w, CW);
        a_if.switch = w;
        a_if.button = 1'b1;
        t = cyc;
        if (rst_at == 0) begin
            e.word = w; e.count = h; e.led = (h != 0); e.done_cyc = t + 3 + W;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        a_if.button = 1'b0;
        if (rst_at > 0) begin
            repeat (rst_at) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("abort busy", a_if.busy, 1'b0);
            check("abort det_valid", a_if.det_valid, 1'b0);
            check("abort hit_count", a_if.hit_count, 0);
            check("abort done", a_if.done, 1'b0);
            repeat (15) begin @(posedge clk); #1; end
            return;
        end
        if (extra) begin
            repeat (3) begin @(posedge clk); #1; end
            a_if.button = 1'b1;
            a_if.switch = 8'hFF;
            @(posedge clk); #1;
            a_if.button = 1'b0;
            @(posedge clk); #1;
            a_if.button = 1'b1;
            a_if.switch = ~w;
            @(posedge clk); #1;
            a_if.button = 1'b0;
        end
        for (int k = 0; k < 40 && ndone == n0; k++) @(posedge clk);
        #1;
        if (ndone == n0) check("done timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        rst = 1'b1;
        a_if.button = 1'b1; a_if.switch = '0;
        b_if.button = 1'b1; b_if.switch = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Button held through reset release must not start a run
        repeat (3) begin
            @(negedge clk);
            check("post-reset det_clr", a_if.det_clr, 1'b0);
            check("post-reset busy", a_if.busy, 1'b0);
            check("post-reset outputs", {a_if.det_valid, a_if.done, a_if.led, a_if.hit_count}, 0);
            check("post-reset B busy", b_if.busy, 1'b0);
        end
        @(posedge clk); #1;
        a_if.button = 1'b0;
        b_if.button = 1'b0;
        @(posedge clk); #1;

        press_a(8'b00011010, 1'b0, 0);
        press_a(8'b10101010, 1'b0, 0);
        press_a(8'h00,       1'b0, 0);
        press_a(8'b10110101, 1'b1, 0);
        press_a(8'b11011011, 1'b0, 0);
        press_a(W'($urandom), 1'b0, 4);
        press_a(8'b00011010, 1'b0, 0);
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            press_a(W'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        // Saturation instance: det_hit tied high gives W hits into a 2-bit counter
        b_if.switch = W'($urandom);
        b_if.button = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        b_if.button = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (b_if.done) break;
        end
        check("sat done seen", (k < 40), 1'b1);
        check("sat hit_count", b_if.hit_count, (W < 3) ? W : 3);
        check("sat led", b_if.led, 1'b1);
        check("sat done cycle", cyc, t + 3 + W);
        $display("saturation run hits=%0d led=%0d", b_if.hit_count, b_if.led);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
